// File: rtl/ddr_render_writer.sv
// ---------------------------------------------------------------------------
// ddr_render_writer
//
// Purpose:
//   Merges up to N_CH Mandelbrot render engines onto one MIG write port.
//   Engines are served round-robin, one BURST_LEN-word burst per grant.
//   Each burst is written into the back frame of a double-buffered frame
//   store. The front and back frames swap once every engine reports that
//   its part of the frame is complete.
//
// Optional feature (macro DDR_RENDER_WRITER_STATS_EN):
//   When defined, the block adds two saturating counters:
//   - burst_count counts commands issued.
//   - stall_count counts LOAD cycles stalled by p_wr_full.
//   Both counters clear on reset and on clear_frame.
//
// Ports:
//   clk, reset          render clock, synchronous active-high reset
//   mem_calib_done      MIG calibration complete
//   ch_ready[i]         channel i holds >= BURST_LEN words
//   ch_data[32i+:32]    channel i head word
//   ch_addr[AW*i+:AW]   channel i word address of its pending burst
//   ch_frame_ready[i]   channel i finished its portion of the frame
//   ch_send_data[i]     pop strobe to channel i
//   clear_frame         one-cycle pulse when the frames swap
//   memory_frame        front frame index; writes go to the other frame
//   p_cmd_*             MIG command port (write, BL = BURST_LEN-1)
//   p_wr_*              MIG write data port
//   burst_count, stall_count   statistics (macro builds only)
// ---------------------------------------------------------------------------
module ddr_render_writer #(
  parameter int          N_CH        = 4,
  parameter int          BURST_LEN   = 16,
  parameter int          ADDR_W      = 21,
  parameter logic [29:0] FRAME_BASE  = 30'h0,
  parameter logic [29:0] FRAME_BYTES = 30'h0080_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_calib_done,
  input  logic [N_CH-1:0]        ch_ready,
  input  logic [32*N_CH-1:0]     ch_data,
  input  logic [ADDR_W*N_CH-1:0] ch_addr,
  input  logic [N_CH-1:0]        ch_frame_ready,
  output logic [N_CH-1:0]        ch_send_data,
  output logic                   clear_frame,
  output logic                   memory_frame,
  output logic                   p_cmd_en,
  output logic [2:0]             p_cmd_instr,
  output logic [5:0]             p_cmd_bl,
  output logic [29:0]            p_cmd_byte_addr,
  output logic                   p_wr_en,
  output logic [31:0]            p_wr_data,
  output logic [3:0]             p_wr_mask,
  input  logic                   p_wr_full,
  input  logic                   p_wr_empty
`ifdef DDR_RENDER_WRITER_STATS_EN
  ,
  output logic [31:0]            burst_count,
  output logic [31:0]            stall_count
`endif
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [5:0] CMD_BL = 6'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_WAIT_CAL = 3'd0,
    S_ARB      = 3'd1,
    S_LOAD     = 3'd2,
    S_CMD      = 3'd3,
    S_SWAP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mf_q, mf_d;
  logic [1:0]         hold_q, hold_d;

  logic               any_ready_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  logic [ADDR_W-1:0]  pick_addr_s;
  logic [31:0]        grant_data_s;
  logic [N_CH-1:0]    grant_onehot_s;
  logic               swap_ok_s;
  logic               push_s;
  logic               last_push_s;
  logic [29:0]        back_base_s;
  logic [31:0]        byte_off_s;
  logic [29:0]        byte_addr_s;

  assign any_ready_s = |ch_ready;
  // ch_frame_ready is ignored for two cycles after a swap.
  // This gives the engines time to drop it in response to clear_frame.
  assign swap_ok_s   = (&ch_frame_ready) && p_wr_empty && (hold_q == 2'd0);
  assign push_s      = (state_q == S_LOAD) && !p_wr_full;
  assign last_push_s = push_s && (cnt_q == CNT_W'(BURST_LEN - 1));

  // The back frame is the one not currently being scanned out.
  assign back_base_s = mf_q ? FRAME_BASE : (FRAME_BASE + FRAME_BYTES);
  assign byte_off_s  = 32'(addr_q) << 2;
  assign byte_addr_s = back_base_s + byte_off_s[29:0];

  // Round-robin pick: the first ready channel at or after the pointer.
  always_comb begin
    int cand;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end else begin
        cand = cand;
      end
      for (int j = 0; j < N_CH; j++) begin
        if (!found_s && (cand == j) && ch_ready[j]) begin
          found_s = 1'b1;
          pick_s  = IDX_W'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Channel muxes: the address of the channel being picked, and the data
  // and pop strobe of the channel currently granted.
  always_comb begin
    pick_addr_s    = '0;
    grant_data_s   = '0;
    grant_onehot_s = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (pick_s == IDX_W'(j)) begin
        pick_addr_s = ch_addr[ADDR_W*j +: ADDR_W];
      end else begin
        pick_addr_s = pick_addr_s;
      end
      if (grant_q == IDX_W'(j)) begin
        grant_data_s      = ch_data[32*j +: 32];
        grant_onehot_s[j] = 1'b1;
      end else begin
        grant_onehot_s[j] = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_CAL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A ready channel takes priority over a frame swap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_CAL: begin
        if (mem_calib_done) state_d = S_ARB;
        else                state_d = S_WAIT_CAL;
      end
      S_ARB: begin
        if (any_ready_s)    state_d = S_LOAD;
        else if (swap_ok_s) state_d = S_SWAP;
        else                state_d = S_ARB;
      end
      S_LOAD: begin
        if (last_push_s) state_d = S_CMD;
        else             state_d = S_LOAD;
      end
      S_CMD:   state_d = S_ARB;
      S_SWAP:  state_d = S_ARB;
      default: state_d = S_WAIT_CAL;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  // The write strobes also depend on p_wr_full, so a stall takes effect
  // in the same cycle.
  always_comb begin
    ch_send_data    = '0;
    p_wr_en         = 1'b0;
    p_wr_data       = 32'h0;
    p_cmd_en        = 1'b0;
    p_cmd_bl        = 6'd0;
    p_cmd_byte_addr = 30'h0;
    clear_frame     = 1'b0;
    case (state_q)
      S_LOAD: begin
        p_wr_data = grant_data_s;
        if (!p_wr_full) begin
          p_wr_en      = 1'b1;
          ch_send_data = grant_onehot_s;
        end else begin
          p_wr_en      = 1'b0;
          ch_send_data = '0;
        end
      end
      S_CMD: begin
        p_cmd_en        = 1'b1;
        p_cmd_bl        = CMD_BL;
        p_cmd_byte_addr = byte_addr_s;
      end
      S_SWAP:  clear_frame = 1'b1;
      default: clear_frame = 1'b0;
    endcase
  end

  assign p_cmd_instr  = 3'b000;
  assign p_wr_mask    = 4'b0000;
  assign memory_frame = mf_q;

  // Datapath next-state logic: grant latch, word count, pointer, frame
  // index and swap hold-off.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mf_d    = mf_q;
    if (state_q == S_SWAP) begin
      hold_d = 2'd2;
    end else if (hold_q != 2'd0) begin
      hold_d = hold_q - 2'd1;
    end else begin
      hold_d = hold_q;
    end
    case (state_q)
      S_ARB: begin
        if (any_ready_s) begin
          grant_d = pick_s;
          addr_d  = pick_addr_s;
          cnt_d   = '0;
        end else if (swap_ok_s) begin
          mf_d = ~mf_q;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOAD: begin
        if (push_s) cnt_d = cnt_q + CNT_W'(1);
        else        cnt_d = cnt_q;
      end
      S_CMD: begin
        if (grant_q == IDX_W'(N_CH - 1)) ptr_d = '0;
        else                             ptr_d = grant_q + IDX_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      mf_q    <= 1'b0;
      hold_q  <= 2'd0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mf_q    <= mf_d;
      hold_q  <= hold_d;
    end
  end

`ifdef DDR_RENDER_WRITER_STATS_EN
  logic [31:0] burst_q, burst_d;
  logic [31:0] stall_q, stall_d;

  // Statistics next-state logic. Counters saturate and clear on each swap.
  always_comb begin
    burst_d = burst_q;
    stall_d = stall_q;
    if (clear_frame) begin
      burst_d = 32'h0;
      stall_d = 32'h0;
    end else begin
      if (p_cmd_en && (burst_q != 32'hFFFF_FFFF)) burst_d = burst_q + 32'd1;
      else                                        burst_d = burst_q;
      if ((state_q == S_LOAD) && p_wr_full && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end else begin
        stall_d = stall_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= 32'h0;
      stall_q <= 32'h0;
    end else begin
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  assign burst_count = burst_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ddr_render_writer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ddr_render_writer (N_CH=4, BURST_LEN=16).
//
// Each render channel is modelled as an endless stream of random words.
// The bench's expectations come from these rules:
//   - round-robin grant order;
//   - in-order delivery of each channel's words;
//   - the back-frame address calculation;
//   - the frame-swap conditions.
// ---------------------------------------------------------------------------
module tb_ddr_render_writer;

  localparam int          N   = 4;
  localparam int          BL  = 16;
  localparam int          AW  = 21;
  localparam logic [29:0] FB  = 30'h0;
  localparam logic [29:0] FBY = 30'h0080_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_calib_done;
  logic [N-1:0]    ch_ready;
  logic [32*N-1:0] ch_data;
  logic [AW*N-1:0] ch_addr;
  logic [N-1:0]    ch_frame_ready;
  logic [N-1:0]    ch_send_data;
  logic            clear_frame;
  logic            memory_frame;
  logic            p_cmd_en;
  logic [2:0]      p_cmd_instr;
  logic [5:0]      p_cmd_bl;
  logic [29:0]     p_cmd_byte_addr;
  logic            p_wr_en;
  logic [31:0]     p_wr_data;
  logic [3:0]      p_wr_mask;
  logic            p_wr_full;
  logic            p_wr_empty;
`ifdef DDR_RENDER_WRITER_STATS_EN
  logic [31:0]     burst_count;
  logic [31:0]     stall_count;
`endif

  always #5 clk = ~clk;

  ddr_render_writer #(
    .N_CH(N), .BURST_LEN(BL), .ADDR_W(AW), .FRAME_BASE(FB), .FRAME_BYTES(FBY)
  ) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .ch_ready(ch_ready), .ch_data(ch_data), .ch_addr(ch_addr),
    .ch_frame_ready(ch_frame_ready), .ch_send_data(ch_send_data),
    .clear_frame(clear_frame), .memory_frame(memory_frame),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_wr_en(p_wr_en), .p_wr_data(p_wr_data),
    .p_wr_mask(p_wr_mask), .p_wr_full(p_wr_full), .p_wr_empty(p_wr_empty)
`ifdef DDR_RENDER_WRITER_STATS_EN
    , .burst_count(burst_count), .stall_count(stall_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Channel model: per-channel word streams and read heads.
  logic [31:0] words [N][512];
  int          head [N];
  int          consumed [N];   // model: words each channel has delivered
  int          rr_ptr;         // model: round-robin pointer

  // Observations taken at the falling edge.
  logic [N-1:0] o_pop;
  logic         o_wr_en, o_cmd_en, o_clear, o_mf;
  logic [31:0]  o_wr_data;
  logic [29:0]  o_cmd_addr;
  logic [5:0]   o_cmd_bl;
  logic [2:0]   o_instr;
  logic [3:0]   o_mask;

  task automatic refresh_data();
    for (int i = 0; i < N; i++) ch_data[32*i +: 32] = words[i][head[i] & 511];
  endtask

  // One clock: sample outputs at negedge, then advance the channel model.
  task automatic cycle();
    @(negedge clk);
    o_pop      = ch_send_data;
    o_wr_en    = p_wr_en;
    o_wr_data  = p_wr_data;
    o_cmd_en   = p_cmd_en;
    o_cmd_addr = p_cmd_byte_addr;
    o_cmd_bl   = p_cmd_bl;
    o_clear    = clear_frame;
    o_mf       = memory_frame;
    o_instr    = p_cmd_instr;
    o_mask     = p_wr_mask;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (reset) head[i] = 0;
      else if (o_pop[i]) head[i] = head[i] + 1;
    end
    refresh_data();
  endtask

  // Reset DUT and channel model. On return (cal=1) the DUT is in ARB.
  task automatic do_reset(input logic cal);
    reset = 1'b1; mem_calib_done = cal; ch_ready = '0; ch_frame_ready = '0;
    p_wr_full = 1'b0; p_wr_empty = 1'b1; ch_addr = '0;
    repeat (3) cycle();
    reset = 1'b0;
    rr_ptr = 0;
    for (int i = 0; i < N; i++) consumed[i] = 0;
    cycle();
  endtask

  function automatic logic [29:0] exp_addr(input logic mf, input logic [AW-1:0] a);
    logic [29:0] base;
    base = mf ? FB : (FB + FBY);
    return base + {7'b0, a, 2'b00};
  endfunction

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if ({o_pop, o_wr_en, o_wr_data, o_cmd_en, o_cmd_addr, o_cmd_bl, o_clear, o_mf,
         o_instr, o_mask} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: pop=%b wr_en=%b data=%h cmd=%b addr=%h bl=%0d clr=%b mf=%b, required all 0",
               o_pop, o_wr_en, o_wr_data, o_cmd_en, o_cmd_addr, o_cmd_bl, o_clear, o_mf);
    end
  endtask

  task automatic test_cal_gate();
    int activity;
    int found;
    logic [N-1:0] first_pop;
    activity = 0; found = -1; first_pop = '0;
    ch_ready = 4'b1111;
    for (int i = 0; i < N; i++) ch_addr[AW*i +: AW] = AW'($urandom);
    repeat (100) begin
      cycle();
      if (o_pop != 0 || o_wr_en || o_cmd_en) activity++;
    end
    total++;
    if (activity !== 0) begin
      bad++;
      $display("FAIL cal_gate_idle: %0d active cycles, required 0", activity);
    end
    mem_calib_done = 1'b1;
    for (int k = 0; k < 10 && found < 0; k++) begin
      cycle();
      if (o_pop != 0) begin
        found = k;
        first_pop = o_pop;
      end
    end
    total++;
    if (found !== 2 || first_pop !== 4'b0001) begin
      bad++;
      $display("FAIL cal_first_pop: at %0d on %b, required 2 on 0001", found, first_pop);
    end
  endtask

  task automatic test_single_burst();
    do_reset(1'b1);
    ch_ready = 4'b0100;
    for (int i = 0; i < N; i++) ch_addr[AW*i +: AW] = AW'($urandom);
    ch_addr[AW*2 +: AW] = 21'h100;
    cycle();
    for (int k = 0; k < BL; k++) begin
      cycle();
      total++;
      if (o_pop !== 4'b0100 || o_wr_en !== 1'b1 || o_wr_data !== words[2][k]) begin
        bad++;
        $display("FAIL single_push%0d: pop=%b wr_en=%b data=%h, required 0100/1/%h",
                 k, o_pop, o_wr_en, o_wr_data, words[2][k]);
      end
    end
    cycle();
    total++;
    if (o_cmd_en !== 1'b1 || o_cmd_addr !== (FBY + 30'h400) || o_cmd_bl !== 6'd15 ||
        o_instr !== 3'b000 || o_mask !== 4'b0000 || o_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL single_cmd: en=%b addr=%h bl=%0d instr=%b wr_en=%b, required 1/%h/15/000/0",
               o_cmd_en, o_cmd_addr, o_cmd_bl, o_instr, o_wr_en, FBY + 30'h400);
    end
  endtask

  task automatic test_round_robin();
    int cyc, pushes, exp_ch, wrong;
    do_reset(1'b1);
    ch_ready = 4'b1111;
    for (int b = 0; b < 6; b++) begin
      exp_ch = b % N;
      cyc = 0; pushes = 0; wrong = 0; o_cmd_en = 1'b0;
      while (!o_cmd_en && cyc < 40) begin
        cycle();
        cyc++;
        if (o_wr_en || o_pop != 0) begin
          if (o_pop !== (4'b0001 << exp_ch) || !o_wr_en ||
              o_wr_data !== words[exp_ch][(consumed[exp_ch] + pushes) & 511]) wrong++;
          pushes++;
        end
      end
      consumed[exp_ch] = consumed[exp_ch] + BL;
      total++;
      if (pushes !== BL || wrong !== 0 || cyc !== BL + 2) begin
        bad++;
        $display("FAIL rr_burst%0d: pushes=%0d wrong=%0d cycles=%0d, required %0d/0/%0d on ch%0d",
                 b, pushes, wrong, cyc, BL, BL + 2, exp_ch);
      end
    end
  endtask

  task automatic test_back_pressure();
    int cyc, pushes, wrong;
    do_reset(1'b1);
    ch_ready = 4'b0001;
    ch_addr[0 +: AW] = 21'h0_1234;
    cycle();
    cyc = 1; pushes = 0; wrong = 0; o_cmd_en = 1'b0;
    while (!o_cmd_en && cyc < 60) begin
      p_wr_full = (cyc >= 5 && cyc <= 9);
      cycle();
      cyc++;
      if (o_wr_en || o_pop != 0) begin
        if (o_pop !== 4'b0001 || !o_wr_en || o_wr_data !== words[0][pushes]) wrong++;
        pushes++;
      end
    end
    p_wr_full = 1'b0;
    total++;
    if (pushes !== BL || wrong !== 0 || cyc !== BL + 2 + 5) begin
      bad++;
      $display("FAIL backpressure: pushes=%0d wrong=%0d cycles=%0d, required %0d/0/%0d",
               pushes, wrong, cyc, BL, BL + 7);
    end
    total++;
    if (o_cmd_addr !== exp_addr(1'b0, 21'h0_1234)) begin
      bad++;
      $display("FAIL backpressure_addr: %h, required %h", o_cmd_addr, exp_addr(1'b0, 21'h0_1234));
    end
`ifdef DDR_RENDER_WRITER_STATS_EN
    total++;
    if (stall_count !== 32'd5 || burst_count !== 32'd1) begin
      bad++;
      $display("FAIL stats: stall=%0d burst=%0d, required 5/1", stall_count, burst_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [N-1:0]  r;
    logic [AW-1:0] a [N];
    int g, c, cyc, pushes;
    logic full_now;
    do_reset(1'b1);
    for (int b = 0; b < 20; b++) begin
      r = 4'($urandom_range(1, 15));
      ch_ready = r;
      for (int i = 0; i < N; i++) begin
        a[i] = AW'($urandom);
        ch_addr[AW*i +: AW] = a[i];
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (rr_ptr + k) % N;
        if (g < 0 && r[c]) g = c;
      end
      cycle();
      total++;
      if (o_pop !== '0 || o_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL rnd_arb%0d: pop=%b wr_en=%b in arbitration cycle, required 0", b, o_pop, o_wr_en);
      end
      pushes = 0; cyc = 0;
      while (pushes < BL && cyc < 80) begin
        full_now = ($urandom_range(0, 3) == 0);
        p_wr_full = full_now;
        if (pushes > 0) begin
          ch_ready = 4'($urandom);
          for (int i = 0; i < N; i++) ch_addr[AW*i +: AW] = AW'($urandom);
        end
        cycle();
        cyc++;
        total++;
        if (full_now) begin
          if (o_wr_en !== 1'b0 || o_pop !== '0 || o_cmd_en !== 1'b0) begin
            bad++;
            $display("FAIL rnd_stall%0d: wr_en=%b pop=%b cmd=%b while full, required 0", b, o_wr_en, o_pop, o_cmd_en);
          end
        end else begin
          if (o_pop !== (4'b0001 << g) || o_wr_en !== 1'b1 ||
              o_wr_data !== words[g][(consumed[g] + pushes) & 511]) begin
            bad++;
            $display("FAIL rnd_push%0d_%0d: pop=%b wr_en=%b data=%h, required ch%0d data=%h",
                     b, pushes, o_pop, o_wr_en, o_wr_data, g, words[g][(consumed[g] + pushes) & 511]);
          end
          pushes++;
        end
      end
      p_wr_full = 1'b0;
      cycle();
      total++;
      if (o_cmd_en !== 1'b1 || o_wr_en !== 1'b0 || o_cmd_addr !== exp_addr(1'b0, a[g]) || o_cmd_bl !== 6'd15) begin
        bad++;
        $display("FAIL rnd_cmd%0d: en=%b wr_en=%b addr=%h bl=%0d, required 1/0/%h/15",
                 b, o_cmd_en, o_wr_en, o_cmd_addr, o_cmd_bl, exp_addr(1'b0, a[g]));
      end
      consumed[g] = consumed[g] + BL;
      rr_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_frame_swap();
    int clears, cyc, first_pop_at, clear_seen;
    do_reset(1'b1);
    ch_frame_ready = 4'b1111;
    p_wr_empty = 1'b0;
    clears = 0;
    repeat (6) begin
      cycle();
      if (o_clear) clears++;
    end
    total++;
    if (clears !== 0 || o_mf !== 1'b0) begin
      bad++;
      $display("FAIL swap_needs_empty: clears=%0d mf=%b, required 0/0", clears, o_mf);
    end
    p_wr_empty = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_clear) begin
        clears++;
        ch_frame_ready = 4'b0000;
      end
    end
    total++;
    if (clears !== 1 || o_mf !== 1'b1) begin
      bad++;
      $display("FAIL swap: clears=%0d mf=%b, required 1/1", clears, o_mf);
    end
    ch_ready = 4'b0010;
    ch_addr = '0;
    cyc = 0; o_cmd_en = 1'b0;
    while (!o_cmd_en && cyc < 30) begin
      cycle();
      cyc++;
    end
    total++;
    if (o_cmd_en !== 1'b1 || o_cmd_addr !== FB) begin
      bad++;
      $display("FAIL swap_next_addr: en=%b addr=%h, required 1/%h", o_cmd_en, o_cmd_addr, FB);
    end
    // Ready beats swap when both are possible.
    ch_ready = 4'b1000;
    ch_frame_ready = 4'b1111;
    first_pop_at = -1; clear_seen = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (o_clear) clear_seen++;
      if (o_pop != 0 && first_pop_at < 0) first_pop_at = k;
    end
    total++;
    if (clear_seen !== 0 || first_pop_at !== 1) begin
      bad++;
      $display("FAIL ready_over_swap: clears=%0d first_pop=%0d, required 0/1", clear_seen, first_pop_at);
    end
    ch_frame_ready = 4'b0000;
  endtask

  task automatic test_reset_mid_load();
    int cyc, pops, cmds, found;
    logic [N-1:0] first_pop;
    do_reset(1'b1);
    ch_ready = 4'b0100;
    cyc = 0; o_cmd_en = 1'b0;
    while (!o_cmd_en && cyc < 30) begin
      cycle();
      cyc++;
    end
    ch_ready = 4'b1000;
    cycle();
    pops = 0; cyc = 0;
    while (pops < 6 && cyc < 30) begin
      cycle();
      cyc++;
      if (o_pop != 0) pops++;
    end
    @(negedge clk);
    total++;
    if (ch_send_data !== 4'b1000) begin
      bad++;
      $display("FAIL reset_mid_7th_pop: pop=%b, required 1000", ch_send_data);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) head[i] = 0;
    refresh_data();
    cycle();
    total++;
    if ({o_pop, o_wr_en, o_wr_data, o_cmd_en, o_cmd_addr, o_cmd_bl, o_clear, o_mf} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: pop=%b wr_en=%b data=%h cmd=%b addr=%h mf=%b, required all 0",
               o_pop, o_wr_en, o_wr_data, o_cmd_en, o_cmd_addr, o_mf);
    end
    reset = 1'b0;
    ch_ready = 4'b1111;
    cmds = 0; found = -1; first_pop = '0;
    for (int k = 0; k < 10 && found < 0; k++) begin
      cycle();
      if (o_cmd_en) cmds++;
      if (o_pop != 0) begin
        found = k;
        first_pop = o_pop;
      end
    end
    total++;
    if (cmds !== 0 || first_pop !== 4'b0001 || found !== 2) begin
      bad++;
      $display("FAIL reset_mid_restart: cmds=%0d first_pop=%b at %0d, required 0/0001 at 2",
               cmds, first_pop, found);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      for (int k = 0; k < 512; k++) words[i][k] = $urandom;
    end
    ch_data = '0;
    refresh_data();
    test_reset();
    test_cal_gate();
    test_single_burst();
    test_round_robin();
    test_back_pressure();
    test_random();
    test_frame_swap();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_render_writer.md
Name: ddr_render_writer

Overview:
- Parametrised successor to the single-engine port-0 write path.
- Merges up to N_CH Mandelbrot rendering engines onto one MIG write port using round-robin burst arbitration.
- Packs each granted engine's words into a BURST_LEN burst and writes it into the back frame of a double-buffered frame store.
- Swaps front/back frames once every engine reports frame complete; the port-1 scan-out path reads the front frame via memory_frame.

Parameters:
N_CH, 4, number of render engine channels (1..8)
BURST_LEN, 16, words per MIG write burst (1..64)
ADDR_W, 21, width of per-channel word address
FRAME_BASE, 30'h0, byte address of frame 0
FRAME_BYTES, 30'h0080_0000, byte offset from frame 0 to frame 1

Ports:
clk  in  1  port clock (render clock domain)
reset  in  1  synchronous active-high reset
mem_calib_done  in  1  MIG calibration complete
ch_ready  in  N_CH  channel i has >= BURST_LEN words buffered
ch_data  in  32*N_CH  channel i head word, slice [32i+31:32i]
ch_addr  in  ADDR_W*N_CH  channel i word address of first word of the pending burst
ch_frame_ready  in  N_CH  channel i finished its portion of the frame
ch_send_data  out  N_CH  pop strobe to channel i, one word per cycle
clear_frame  out  1  one-cycle pulse after a frame swap
memory_frame  out  1  front frame index; writes target ~memory_frame
p_cmd_en  out  1  MIG command strobe
p_cmd_instr  out  3  always 3'b000 (write)
p_cmd_bl  out  6  BURST_LEN-1
p_cmd_byte_addr  out  30  burst byte address
p_wr_en  out  1  MIG write FIFO push
p_wr_data  out  32  write word
p_wr_mask  out  4  always 4'b0000
p_wr_full  in  1  MIG write FIFO full
p_wr_empty  in  1  MIG write FIFO empty

Behaviour:
- Reset values: all outputs 0; grant pointer = 0; state WAIT_CAL.
- Reset mid-burst: abandon the burst immediately, with no cmd_en. Channels are reset by the same signal.
- WAIT_CAL: stay until mem_calib_done=1, then go to ARB.
- ARB:
  - If any ch_ready, grant the first set bit at or after the pointer (round-robin), latch its index and ch_addr, and go to LOAD.
  - Else if all ch_frame_ready=1 and p_wr_empty=1, go to SWAP.
  - Else remain.
  - Ready takes priority over swap.
- LOAD:
  - Each cycle with p_wr_full=0: p_wr_en=1, p_wr_data=ch_data[grant], ch_send_data[grant]=1, increment the word counter.
  - With p_wr_full=1: both strobes are 0 and data is held (stall).
  - After the BURST_LEN-th push, go to CMD.
  - ch_send_data and p_wr_en are always identical, one-hot or zero.
- CMD:
  - One cycle: p_cmd_en=1.
  - p_cmd_byte_addr = (back base) + (latched ch_addr << 2), truncated to 30 bits.
  - back base = FRAME_BASE if memory_frame=1, else FRAME_BASE+FRAME_BYTES.
  - Pointer = grant+1, wrapping from N_CH-1 to 0. Go to ARB.
- SWAP: toggle memory_frame and pulse clear_frame=1 for exactly one cycle, then go to ARB.
- ch_frame_ready must drop within 2 cycles of clear_frame. The block ignores ch_frame_ready for 2 cycles after SWAP.
- Latency: ch_ready at ARB to first pop = 1 cycle. Unstalled burst = BURST_LEN+2 cycles, ARB to ARB.
- Command ordering: the command is always issued after all BURST_LEN data words are in the FIFO. Never more than one burst outstanding in the FIFO-fill phase.
- Channels with ch_ready=0 are never popped. The grant is held for the whole burst even if ch_ready drops.

Optional Feature:
- Macro: DDR_RENDER_WRITER_STATS_EN.
- When defined, adds outputs burst_count[31:0] and stall_count[31:0]:
  - burst_count increments on each p_cmd_en.
  - stall_count increments on each LOAD cycle with p_wr_full=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset and on clear_frame.
- When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Calibration gate: mem_calib_done=0 for 100 cycles with ch_ready=4'b1111 -> no ch_send_data, p_wr_en or p_cmd_en. Calibration rises -> first pop 2 cycles later, on channel 0.
- Single burst (N_CH=4, BURST_LEN=16): channel 2 ready, ch_addr=0x100, memory_frame=0 -> 16 pops of ch_data[2] in 16 consecutive cycles, then p_cmd_en with byte_addr=FRAME_BYTES+0x400 and p_cmd_bl=15.
- Round-robin: all 4 channels continuously ready -> grant order 0,1,2,3,0,1; each burst 16 pops; 18 cycles per burst.
- Back-pressure: assert p_wr_full for cycles 5-9 of a burst -> exactly 16 pushes with no data loss or duplication, p_cmd_en delayed 5 cycles; with STATS_EN, stall_count=5.
- Frame swap: all ch_frame_ready=1 with p_wr_empty=1 and no ch_ready -> memory_frame 0->1, one-cycle clear_frame. The next burst at ch_addr=0 goes to byte_addr=FRAME_BASE.
- Reset mid-LOAD: reset after the 7th pop -> all outputs 0 next cycle, no p_cmd_en, memory_frame=0, pointer=0.
